// File: rtl/digit_entry_ctrl.sv
// Operand digit entry: button sync/debounce, press capture, round-robin
// increment of four independent BCD digits, with lock and clear.
module digit_entry_ctrl #(
    parameter int DB_CYCLES = 500000,
    parameter int DB_W      = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] but,
    input  logic       lock,
    input  logic       clear,
    output logic [3:0] n1dig1,
    output logic [3:0] n1dig0,
    output logic [3:0] n2dig1,
    output logic [3:0] n2dig0,
    output logic       upd,
    output logic [1:0] upd_idx,
    output logic [3:0] pending
);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic [3:0]      sync1;
    logic [3:0]      s;
    logic [3:0]      stable;
    logic [3:0]      stable_q;
    logic [DB_W-1:0] cnt [4];
    logic [3:0]      dig [4];
    logic [1:0]      rr;
    logic [3:0]      rise;
    logic            gnt_v;
    logic [1:0]      gnt;
    logic [1:0]      idx;
    logic [3:0]      gnt_mask;

    assign rise = stable & ~stable_q;

    // Round-robin search starting at rr; clear and lock suppress any grant.
    always_comb begin
        gnt_v = 1'b0;
        gnt   = rr;
        idx   = rr;
        if (!lock && !clear) begin
            for (int i = 0; i < 4; i++) begin
                idx = rr + 2'(i);
                if (!gnt_v && pending[idx]) begin
                    gnt_v = 1'b1;
                    gnt   = idx;
                end
            end
        end
        gnt_mask = gnt_v ? (4'b0001 << gnt) : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= '0;
            s        <= '0;
            stable   <= '0;
            stable_q <= '0;
            pending  <= '0;
            upd      <= 1'b0;
            upd_idx  <= '0;
            rr       <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
                dig[i] <= '0;
            end
        end else begin
            sync1    <= but;
            s        <= sync1;
            stable_q <= stable;

            for (int i = 0; i < 4; i++) begin
                if (s[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DB_LAST) begin
                    stable[i] <= s[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + DB_W'(1);
                end
            end

            // Clear leaves debounce state and rr alone so entry resumes cleanly.
            if (clear) begin
                pending <= '0;
                upd     <= 1'b0;
                for (int i = 0; i < 4; i++) begin
                    dig[i] <= '0;
                end
            end else begin
                upd     <= gnt_v;
                pending <= (pending & ~gnt_mask) | rise;
                if (gnt_v) begin
                    upd_idx  <= gnt;
                    dig[gnt] <= (dig[gnt] == 4'd9) ? 4'd0 : dig[gnt] + 4'd1;
                    rr       <= gnt + 2'd1;
                end
            end
        end
    end

    assign n1dig0 = dig[0];
    assign n1dig1 = dig[1];
    assign n2dig0 = dig[2];
    assign n2dig1 = dig[3];

endmodule

// File: tb/tb_digit_entry_ctrl.sv
// Directed bench for digit_entry_ctrl with a short debounce window (4 cycles).
module tb_digit_entry_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] but;
    logic       lock;
    logic       clear;
    logic [3:0] n1dig1, n1dig0, n2dig1, n2dig0;
    logic       upd;
    logic [1:0] upd_idx;
    logic [3:0] pending;

    int n_cmp = 0;
    int n_err = 0;
    int upd_cnt [4];

    digit_entry_ctrl #(.DB_CYCLES(4), .DB_W(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .but     (but),
        .lock    (lock),
        .clear   (clear),
        .n1dig1  (n1dig1),
        .n1dig0  (n1dig0),
        .n2dig1  (n2dig1),
        .n2dig0  (n2dig0),
        .upd     (upd),
        .upd_idx (upd_idx),
        .pending (pending)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; sample 1 ns after the edge and tally update pulses.
    task automatic step();
        @(posedge clk);
        #1;
        if (upd === 1'b1) upd_cnt[upd_idx]++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clr_cnt();
        for (int i = 0; i < 4; i++) upd_cnt[i] = 0;
    endtask

    function automatic int upd_total();
        return upd_cnt[0] + upd_cnt[1] + upd_cnt[2] + upd_cnt[3];
    endfunction

    task automatic check_digits(input string tag, input logic [3:0] e0, input logic [3:0] e1,
                                input logic [3:0] e2, input logic [3:0] e3);
        check_val({tag, "_n1dig0"}, 32'(n1dig0), 32'(e0));
        check_val({tag, "_n1dig1"}, 32'(n1dig1), 32'(e1));
        check_val({tag, "_n2dig0"}, 32'(n2dig0), 32'(e2));
        check_val({tag, "_n2dig1"}, 32'(n2dig1), 32'(e3));
    endtask

    initial begin
        rst = 1'b1; but = '0; lock = 1'b0; clear = 1'b0;
        clr_cnt();
        run(2);
        check_digits("reset", 0, 0, 0, 0);
        check_val("reset_upd", 32'(upd), 0);
        check_val("reset_idx", 32'(upd_idx), 0);
        check_val("reset_pend", 32'(pending), 0);
        rst = 1'b0;
        run(2);

        // Single press: digit visible on the 8th edge after the raw rise.
        clr_cnt();
        but = 4'b0001;
        run(7);
        check_val("single_pend", 32'(pending), 32'h1);
        check_val("single_early", 32'(n1dig0), 0);
        step();
        check_val("single_upd", 32'(upd), 1);
        check_val("single_idx", 32'(upd_idx), 0);
        check_val("single_dig", 32'(n1dig0), 1);
        run(12);
        check_val("single_once", 32'(upd_total()), 1);
        check_digits("single", 1, 0, 0, 0);
        but = '0;
        run(10);

        // Bounce on but[2], then a clean hold.
        clr_cnt();
        for (int k = 0; k < 6; k++) begin
            but[2] = ~but[2];
            run(2);
        end
        run(8);
        check_val("bounce_none", 32'(upd_total()), 0);
        check_val("bounce_pend", 32'(pending), 0);
        but[2] = 1'b1;
        run(12);
        check_val("bounce_hold_cnt", 32'(upd_cnt[2]), 1);
        check_val("bounce_hold_dig", 32'(n2dig0), 1);
        but = '0;
        run(10);
        clr_cnt();
        but[2] = 1'b1;
        run(3);
        but[2] = 1'b0;
        run(12);
        check_val("pulse3_none", 32'(upd_total()), 0);
        check_val("pulse3_dig", 32'(n2dig0), 1);

        // Wrap: ten presses of but[3].
        for (int p = 0; p < 10; p++) begin
            but = 4'b1000;
            run(10);
            check_val($sformatf("wrap_%0d", p), 32'(n2dig1), 32'((p + 1) % 10));
            but = '0;
            run(10);
        end
        check_val("wrap_n2dig0", 32'(n2dig0), 1);

        // Clear to a known base, then four simultaneous presses from rr=0.
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_digits("clr_base", 0, 0, 0, 0);
        for (int r = 0; r < 2; r++) begin
            but = 4'hF;
            run(7);
            check_val($sformatf("cont%0d_pend", r), 32'(pending), 32'hF);
            for (int i = 0; i < 4; i++) begin
                step();
                check_val($sformatf("cont%0d_upd%0d", r, i), 32'(upd), 1);
                check_val($sformatf("cont%0d_idx%0d", r, i), 32'(upd_idx), 32'(i));
            end
            step();
            check_val($sformatf("cont%0d_quiet", r), 32'(upd), 0);
            check_digits($sformatf("cont%0d", r), 4'(r + 1), 4'(r + 1), 4'(r + 1), 4'(r + 1));
            but = '0;
            run(10);
        end

        // Lock holds presses as pending; release services 0 then 1.
        clr_cnt();
        lock = 1'b1;
        but = 4'b0011;
        run(12);
        check_val("lock_pend", 32'(pending), 32'h3);
        check_val("lock_noupd", 32'(upd_total()), 0);
        check_digits("lock", 2, 2, 2, 2);
        but = '0;
        run(10);
        lock = 1'b0;
        step();
        check_val("unlock_upd0", 32'(upd), 1);
        check_val("unlock_idx0", 32'(upd_idx), 0);
        check_val("unlock_dig0", 32'(n1dig0), 3);
        step();
        check_val("unlock_idx1", 32'(upd_idx), 1);
        check_val("unlock_dig1", 32'(n1dig1), 3);
        step();
        check_val("unlock_quiet", 32'(upd), 0);
        check_val("unlock_pend", 32'(pending), 0);

        // Clear wins over a grant that would otherwise happen this cycle.
        lock = 1'b1;
        but = 4'b0100;
        run(12);
        but = '0;
        run(10);
        check_val("pre_clear_pend", 32'(pending), 32'h4);
        lock = 1'b0;
        clear = 1'b1;
        step();
        check_digits("clear", 0, 0, 0, 0);
        check_val("clear_pend", 32'(pending), 0);
        check_val("clear_upd", 32'(upd), 0);
        clear = 1'b0;
        step();
        check_val("post_clear_upd", 32'(upd), 0);

        // Reset while but[1] is held: debounce restarts from zero.
        but = 4'b0010;
        run(8);
        check_val("held_dig", 32'(n1dig1), 1);
        run(2);
        rst = 1'b1;
        step();
        check_digits("rst_mid", 0, 0, 0, 0);
        check_val("rst_mid_pend", 32'(pending), 0);
        check_val("rst_mid_upd", 32'(upd), 0);
        rst = 1'b0;
        clr_cnt();
        run(7);
        check_val("rst_redb_early", 32'(n1dig1), 0);
        step();
        check_val("rst_redb_dig", 32'(n1dig1), 1);
        check_val("rst_redb_idx", 32'(upd_idx), 1);
        run(10);
        check_val("rst_redb_once", 32'(upd_total()), 1);
        but = '0;
        run(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
